// File: rtl/i2c_target_regfile.sv
// I2C target with a 256x8 register file: pointer-byte writes, sequential reads, write side-band strobe.
// Bus pins are oversampled by clk (3-cycle edge latency); sda is driven open-drain, low only.
module i2c_target_regfile #(
  parameter logic [6:0] DEV_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  output logic       busy,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data
);

  typedef enum logic [3:0] {
    sIdle, sAddr, sAddrAck, sReg, sRegAck,
    sWdata, sWdataAck, sRdata, sRdataAck, sIgnore
  } state_t;

  state_t     state, stateNxt;
  logic [2:0] sclSh, sdaSh;
  logic [2:0] bitCnt, bitCntNxt;
  logic [7:0] shReg, shRegNxt;
  logic [7:0] ptr, ptrNxt;
  logic       rw, rwNxt;
  logic       mAck, mAckNxt;
  logic       sdaDrvLow, sdaDrvLowNxt;
  logic       busyNxt, wrValidNxt;
  logic [7:0] wrAddrNxt, wrDataNxt;
  logic       memWe;
  logic [7:0] mem [256];
  logic [7:0] rdByte;

  logic sclRise, sclFall, sdaRise, sdaFall, sdaSync, startDet, stopDet;

  assign sda = sdaDrvLow ? 1'b0 : 1'bz;

  // Synchronizer resets to the idle-bus level so reset itself never looks like a bus edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sclSh <= 3'b111;
      sdaSh <= 3'b111;
    end else begin
      sclSh <= {sclSh[1:0], scl};
      sdaSh <= {sdaSh[1:0], sda};
    end
  end

  assign sdaSync = sdaSh[1];
  assign sclRise = sclSh[1] & ~sclSh[2];
  assign sclFall = ~sclSh[1] & sclSh[2];
  assign sdaRise = sdaSh[1] & ~sdaSh[2];
  assign sdaFall = ~sdaSh[1] & sdaSh[2];
  // Requiring scl high in both samples excludes coincident scl edges, which count as data changes.
  assign startDet = sdaFall & sclSh[1] & sclSh[2];
  assign stopDet  = sdaRise & sclSh[1] & sclSh[2];

  assign rdByte = mem[ptr];

  always_comb begin
    stateNxt     = state;
    bitCntNxt    = bitCnt;
    shRegNxt     = shReg;
    ptrNxt       = ptr;
    rwNxt        = rw;
    mAckNxt      = mAck;
    sdaDrvLowNxt = sdaDrvLow;
    busyNxt      = busy;
    wrValidNxt   = 1'b0;
    wrAddrNxt    = wr_addr;
    wrDataNxt    = wr_data;
    memWe        = 1'b0;

    if (stopDet) begin
      stateNxt     = sIdle;
      bitCntNxt    = '0;
      sdaDrvLowNxt = 1'b0;
      busyNxt      = 1'b0;
    end else if (startDet) begin
      stateNxt     = sAddr;
      bitCntNxt    = '0;
      sdaDrvLowNxt = 1'b0;
    end else begin
      case (state)
        sAddr: begin
          if (sclRise) begin
            shRegNxt  = {shReg[6:0], sdaSync};
            bitCntNxt = bitCnt + 3'd1;
            if (bitCnt == 3'd7) begin
              if (shReg[6:0] == DEV_ADDR) begin
                stateNxt = sAddrAck;
                rwNxt    = sdaSync;
                busyNxt  = 1'b1;
              end else begin
                stateNxt = sIgnore;
                busyNxt  = 1'b0;
              end
            end
          end
        end

        // Each ACK state sees two falls: the first starts the ACK drive, the second ends it.
        sAddrAck: begin
          if (sclFall) begin
            if (!sdaDrvLow) begin
              sdaDrvLowNxt = 1'b1;
            end else begin
              bitCntNxt = '0;
              if (rw) begin
                stateNxt     = sRdata;
                shRegNxt     = rdByte;
                sdaDrvLowNxt = ~rdByte[7];
              end else begin
                stateNxt     = sReg;
                sdaDrvLowNxt = 1'b0;
              end
            end
          end
        end

        sReg, sWdata: begin
          if (sclRise) begin
            shRegNxt  = {shReg[6:0], sdaSync};
            bitCntNxt = bitCnt + 3'd1;
            if (bitCnt == 3'd7)
              stateNxt = (state == sReg) ? sRegAck : sWdataAck;
          end
        end

        sRegAck: begin
          if (sclFall) begin
            if (!sdaDrvLow) begin
              sdaDrvLowNxt = 1'b1;
            end else begin
              sdaDrvLowNxt = 1'b0;
              ptrNxt       = shReg;
              bitCntNxt    = '0;
              stateNxt     = sWdata;
            end
          end
        end

        sWdataAck: begin
          if (sclFall) begin
            if (!sdaDrvLow) begin
              sdaDrvLowNxt = 1'b1;
              memWe        = 1'b1;
              wrValidNxt   = 1'b1;
              wrAddrNxt    = ptr;
              wrDataNxt    = shReg;
              ptrNxt       = ptr + 8'd1;
            end else begin
              sdaDrvLowNxt = 1'b0;
              bitCntNxt    = '0;
              stateNxt     = sWdata;
            end
          end
        end

        // Bit 7 is already on the bus at entry; each fall presents the next bit, the 8th releases.
        sRdata: begin
          if (sclFall) begin
            if (bitCnt == 3'd7) begin
              sdaDrvLowNxt = 1'b0;
              bitCntNxt    = '0;
              stateNxt     = sRdataAck;
            end else begin
              bitCntNxt    = bitCnt + 3'd1;
              shRegNxt     = {shReg[6:0], 1'b0};
              sdaDrvLowNxt = ~shReg[6];
            end
          end
        end

        sRdataAck: begin
          if (sclRise) begin
            mAckNxt = sdaSync;
            ptrNxt  = ptr + 8'd1;
          end else if (sclFall) begin
            if (!mAck) begin
              stateNxt     = sRdata;
              shRegNxt     = rdByte;
              sdaDrvLowNxt = ~rdByte[7];
            end else begin
              stateNxt = sIgnore;
            end
          end
        end

        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= sIdle;
      bitCnt    <= '0;
      shReg     <= '0;
      ptr       <= '0;
      rw        <= 1'b0;
      mAck      <= 1'b0;
      sdaDrvLow <= 1'b0;
      busy      <= 1'b0;
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      state     <= stateNxt;
      bitCnt    <= bitCntNxt;
      shReg     <= shRegNxt;
      ptr       <= ptrNxt;
      rw        <= rwNxt;
      mAck      <= mAckNxt;
      sdaDrvLow <= sdaDrvLowNxt;
      busy      <= busyNxt;
      wr_valid  <= wrValidNxt;
      wr_addr   <= wrAddrNxt;
      wr_data   <= wrDataNxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (memWe) begin
      mem[ptr] <= shReg;
    end
  end

endmodule
